// File: rtl/synaptic_rmw_engine_pkg.sv
// Shared definitions for the synaptic read-modify-write engine:
// operation encodings, FSM state type and width-generic saturation helpers.
package syn_rmw_pkg;

    localparam int OP_WIDTH = 2;

    localparam logic [OP_WIDTH-1:0] OP_READ  = 2'd0;
    localparam logic [OP_WIDTH-1:0] OP_ACCUM = 2'd1;
    localparam logic [OP_WIDTH-1:0] OP_APPLY = 2'd2;
    localparam logic [OP_WIDTH-1:0] OP_CLEAR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CALC,
        WR,
        DONE
    } rmwStateT;

    // Largest value representable in an n-bit signed field.
    function automatic logic signed [31:0] satMax(input int unsigned n);
        return (32'sd1 <<< (n - 1)) - 32'sd1;
    endfunction

    // Smallest value representable in an n-bit signed field.
    function automatic logic signed [31:0] satMin(input int unsigned n);
        return -satMax(n) - 32'sd1;
    endfunction

    // Clamp a wide signed value into the n-bit signed range.
    function automatic logic signed [31:0] satClamp(input logic signed [31:0] x,
                                                    input int unsigned n);
        if (x > satMax(n)) begin
            return satMax(n);
        end else if (x < satMin(n)) begin
            return satMin(n);
        end
        return x;
    endfunction

    // True when the value falls outside the n-bit signed range.
    function automatic logic satHit(input logic signed [31:0] x,
                                    input int unsigned n);
        return (x > satMax(n)) || (x < satMin(n));
    endfunction

endpackage

// File: rtl/synaptic_rmw_engine_if.sv
// Controller-facing bus of the synaptic RMW engine: request handshake,
// response words and status. The controller uses 'master', the engine 'slave'.
interface synaptic_rmw_engine_if
    import syn_rmw_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int GRAD_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 16,
    parameter int SHIFT_WIDTH   = 3,
    parameter int SAT_CNT_WIDTH = 16
);

    logic                            REQ_VALID;
    logic                            REQ_READY;
    logic [OP_WIDTH-1:0]             REQ_OP;
    logic [ADDR_WIDTH-1:0]           REQ_ADDR;
    logic [LANES*GRAD_WIDTH-1:0]     REQ_DELTA;
    logic [SHIFT_WIDTH-1:0]          LR_SHIFT;
    logic                            RSP_VALID;
    logic [LANES*WEIGHT_WIDTH-1:0]   RSP_WDATA;
    logic [LANES*GRAD_WIDTH-1:0]     RSP_GDATA;
    logic [SAT_CNT_WIDTH-1:0]        SAT_CNT;
    logic                            BUSY;

    modport master (
        output REQ_VALID, REQ_OP, REQ_ADDR, REQ_DELTA, LR_SHIFT,
        input  REQ_READY, RSP_VALID, RSP_WDATA, RSP_GDATA, SAT_CNT, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_ADDR, REQ_DELTA, LR_SHIFT,
        output REQ_READY, RSP_VALID, RSP_WDATA, RSP_GDATA, SAT_CNT, BUSY
    );

endinterface

// File: rtl/sram_synaptic_sim.sv
// Behavioural single-port synchronous SRAM used for the weight and gradient
// banks. Read data appears the cycle after a CS=1/WE=0 access; contents are
// never reset.
module sram_synaptic_sim #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  cs_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Single access port: a selected cycle either writes or registers a read.
    always_ff @(posedge clk_i) begin
        if (cs_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/synaptic_rmw_engine_lane_alu.sv
// Per-lane arithmetic of the synaptic RMW engine (one post-neuron).
// Operands are sign-extended to 32 bits, which is wider than the
// width+1 headroom the sums need, so the clamp sees the exact result.
module syn_lane_alu
    import syn_rmw_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 8,
    parameter int GRAD_WIDTH   = 8,
    parameter int SHIFT_WIDTH  = 3
) (
    input  logic [OP_WIDTH-1:0]            op_i,
    input  logic [SHIFT_WIDTH-1:0]         shift_i,
    input  logic signed [WEIGHT_WIDTH-1:0] w_i,
    input  logic signed [GRAD_WIDTH-1:0]   g_i,
    input  logic signed [GRAD_WIDTH-1:0]   d_i,
    output logic signed [WEIGHT_WIDTH-1:0] w_o,
    output logic signed [GRAD_WIDTH-1:0]   g_o,
    output logic                           sat_o
);

    logic signed [31:0] wExt;
    logic signed [31:0] gExt;
    logic signed [31:0] dExt;
    logic signed [31:0] gShift;
    logic signed [31:0] sum;

    assign wExt   = 32'(w_i);
    assign gExt   = 32'(g_i);
    assign dExt   = 32'(d_i);
    assign gShift = gExt >>> shift_i;

    // Compute the lane's new weight/gradient and whether a clamp happened.
    always_comb begin
        w_o   = w_i;
        g_o   = g_i;
        sat_o = 1'b0;
        sum   = '0;
        case (op_i)
            OP_ACCUM: begin
                sum   = gExt + dExt;
                g_o   = GRAD_WIDTH'(satClamp(sum, GRAD_WIDTH));
                sat_o = satHit(sum, GRAD_WIDTH);
            end
            OP_APPLY: begin
                sum   = wExt - gShift;
                w_o   = WEIGHT_WIDTH'(satClamp(sum, WEIGHT_WIDTH));
                g_o   = '0;
                sat_o = satHit(sum, WEIGHT_WIDTH);
            end
            OP_CLEAR: begin
                g_o = '0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/synaptic_rmw_engine.sv
// Synaptic read-modify-write engine: one weight bank and one gradient bank,
// each request runs RD -> CALC -> (WR) -> DONE across LANES post-neurons.
// Optional build macro SYN_ZERO_SKIP_EN: an ACCUM with an all-zero delta
// bypasses the SRAMs and completes directly from IDLE.
module synaptic_rmw_engine
    import syn_rmw_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int GRAD_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 16,
    parameter int SHIFT_WIDTH   = 3,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    synaptic_rmw_engine_if.slave  bus
);

    localparam int WW = LANES * WEIGHT_WIDTH;
    localparam int GW = LANES * GRAD_WIDTH;

    rmwStateT state_q, state_d;

    logic [OP_WIDTH-1:0]      op_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [GW-1:0]            delta_q;
    logic [SHIFT_WIDTH-1:0]   shift_q;
    logic [WW-1:0]            newW_q;
    logic [GW-1:0]            newG_q;
    logic [WW-1:0]            rspW_q;
    logic [GW-1:0]            rspG_q;
    logic [SAT_CNT_WIDTH-1:0] satCnt_q, satCnt_d;

    logic [WW-1:0]            wRdata;
    logic [GW-1:0]            gRdata;
    logic [WW-1:0]            aluW;
    logic [GW-1:0]            aluG;
    logic [LANES-1:0]         satVec;
    logic [SAT_CNT_WIDTH:0]   satSum;
    logic                     bankCs;
    logic                     bankWe;
    logic                     accept;
    logic                     skipZero;

    assign accept = (state_q == IDLE) && bus.REQ_VALID;

`ifdef SYN_ZERO_SKIP_EN
    assign skipZero = (bus.REQ_OP == OP_ACCUM) && (bus.REQ_DELTA == '0);
`else
    assign skipZero = 1'b0;
`endif

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: READ finishes after CALC, all other ops write back first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = skipZero ? DONE : RD;
                end
            end
            RD:      state_d = CALC;
            CALC:    state_d = (op_q == OP_READ) ? DONE : WR;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake, status and the shared bank controls.
    always_comb begin
        bus.REQ_READY = (state_q == IDLE) && RST_N;
        bus.BUSY      = (state_q != IDLE);
        bus.RSP_VALID = (state_q == DONE);
        bankCs        = (state_q == RD) || (state_q == WR);
        bankWe        = (state_q == WR);
    end

    // Saturation counter advances by the number of lanes that clamped.
    always_comb begin
        satSum = {1'b0, satCnt_q};
        for (int i = 0; i < LANES; i++) begin
            satSum = satSum + (SAT_CNT_WIDTH+1)'(satVec[i]);
        end
        satCnt_d = satSum[SAT_CNT_WIDTH] ? '1 : satSum[SAT_CNT_WIDTH-1:0];
    end

    // Datapath: latch the request, capture new words in CALC, publish on DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q     <= OP_READ;
            addr_q   <= '0;
            delta_q  <= '0;
            shift_q  <= '0;
            newW_q   <= '0;
            newG_q   <= '0;
            rspW_q   <= '0;
            rspG_q   <= '0;
            satCnt_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= bus.REQ_OP;
                addr_q  <= bus.REQ_ADDR;
                delta_q <= bus.REQ_DELTA;
                shift_q <= bus.LR_SHIFT;
            end
            if (state_q == CALC) begin
                newW_q   <= aluW;
                newG_q   <= aluG;
                satCnt_q <= satCnt_d;
            end
            if ((state_d == DONE) && (state_q != IDLE)) begin
                rspW_q <= (state_q == CALC) ? aluW : newW_q;
                rspG_q <= (state_q == CALC) ? aluG : newG_q;
            end
        end
    end

    assign bus.RSP_WDATA = rspW_q;
    assign bus.RSP_GDATA = rspG_q;
    assign bus.SAT_CNT   = satCnt_q;

    sram_synaptic_sim #(
        .DATA_WIDTH (WW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uWeightBank (
        .clk_i   (CLK),
        .cs_i    (bankCs),
        .we_i    (bankWe),
        .addr_i  (addr_q),
        .wdata_i (newW_q),
        .rdata_o (wRdata)
    );

    sram_synaptic_sim #(
        .DATA_WIDTH (GW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uGradBank (
        .clk_i   (CLK),
        .cs_i    (bankCs),
        .we_i    (bankWe),
        .addr_i  (addr_q),
        .wdata_i (newG_q),
        .rdata_o (gRdata)
    );

    for (genvar i = 0; i < LANES; i++) begin : gLane
        syn_lane_alu #(
            .WEIGHT_WIDTH (WEIGHT_WIDTH),
            .GRAD_WIDTH   (GRAD_WIDTH),
            .SHIFT_WIDTH  (SHIFT_WIDTH)
        ) uAlu (
            .op_i    (op_q),
            .shift_i (shift_q),
            .w_i     (wRdata[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .g_i     (gRdata[i*GRAD_WIDTH +: GRAD_WIDTH]),
            .d_i     (delta_q[i*GRAD_WIDTH +: GRAD_WIDTH]),
            .w_o     (aluW[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .g_o     (aluG[i*GRAD_WIDTH +: GRAD_WIDTH]),
            .sat_o   (satVec[i])
        );
    end

endmodule
